// File: rtl/oam_dma_arbiter.sv
// OAM sprite-DMA bus arbiter: shares the CPU bus with a 256-byte
// page-to-OAM copy engine triggered by a CPU register write.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter bit          ALIGN_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw_n,
  output logic [7:0]  cpu_din,
  output logic        cpu_halt,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_rw_n,
  input  logic [7:0]  bus_din,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        parity;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_reg;
  logic        trig;
  logic        last;

  assign trig = (state == IDLE)
              && !cpu_rw_n
              && (cpu_addr == DMA_REG_ADDR);
  assign last = (idx == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      parity   <= 1'b0;
      page     <= 8'h00;
      idx      <= 8'h00;
      data_reg <= 8'h00;
      dma_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      parity   <= ~parity;
      dma_done <= (state == WRITE) && last;
      if (trig) begin
        page <= cpu_dout;
        idx  <= 8'h00;
      end
      if (state == READ)
        data_reg <= bus_din;
      // index wraps inside the page; page byte is never carried into
      if ((state == WRITE) && !last)
        idx <= idx + 8'h01;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_addr  = cpu_addr;
    bus_dout  = cpu_dout;
    bus_rw_n  = cpu_rw_n;
    unique case (state)
      IDLE: begin
        if (trig)
          state_nxt = HALT;
      end
      HALT: begin
        bus_rw_n  = 1'b1;
        state_nxt = (ALIGN_EN && !parity) ? ALIGN : READ;
      end
      ALIGN: begin
        bus_rw_n  = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        bus_addr  = {page, idx};
        bus_rw_n  = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_dout  = data_reg;
        bus_rw_n  = 1'b0;
        state_nxt = last ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_din    = bus_din;
  assign cpu_halt   = (state != IDLE);
  assign dma_active = (state == ALIGN)
                   || (state == READ)
                   || (state == WRITE);

endmodule
